// File: rtl/rr_burst_arbiter_if.sv
// rtl/rr_burst_arbiter_if.sv - request/grant and registered beat bundle for rr_burst_arbiter
interface rr_burst_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 64
);
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]             req_i;
  logic [NUM_PORTS-1:0]             last_i;
  logic [NUM_PORTS-1:0][DATA_W-1:0] data_i;
  logic                             ready_i;
  logic [NUM_PORTS-1:0]             gnt_o;
  logic                             valid_o;
  logic [PORT_W-1:0]                port_o;
  logic [DATA_W-1:0]                data_o;
  logic                             last_o;
  logic                             lock_break_o;

  modport master (
    output req_i, last_i, data_i, ready_i,
    input  gnt_o, valid_o, port_o, data_o, last_o, lock_break_o
  );

  modport slave (
    input  req_i, last_i, data_i, ready_i,
    output gnt_o, valid_o, port_o, data_o, last_o, lock_break_o
  );
endinterface

// File: rtl/rr_burst_arbiter.sv
// rtl/rr_burst_arbiter.sv - round-robin N:1 arbiter with burst lock and forced release
// Optional per-port beat counters are built when ARB_STATS_EN is defined.
module rr_burst_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  rr_burst_arbiter_if.slave           bus,
  input  logic                        stats_clr_i,
  output logic [NUM_PORTS-1:0][15:0]  grant_cnt_o
);
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int BCNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state, state_n;
  logic [PORT_W-1:0] ptr, ptr_n, owner, owner_n, winner, cand;
  logic [BCNT_W-1:0] beat_cnt, beat_cnt_n;
  logic              found, xfer, win_last, lb_n;

  logic              valid_q, last_q, lb_q;
  logic [PORT_W-1:0] port_q;
  logic [DATA_W-1:0] data_q;

  function automatic logic [PORT_W-1:0] next_port(input logic [PORT_W-1:0] p);
    return (p == PORT_W'(NUM_PORTS - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reverse scan so the lowest offset from ptr is the last assignment and wins.
  always_comb begin
    found  = 1'b0;
    winner = owner;
    cand   = '0;
    if (state == LOCKED) begin
      found = bus.req_i[owner];
    end else begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        cand = PORT_W'((int'(ptr) + i) % NUM_PORTS);
        if (bus.req_i[cand]) begin
          found  = 1'b1;
          winner = cand;
        end
      end
    end
  end

  assign xfer     = found && bus.ready_i;
  assign win_last = bus.last_i[winner];

  always_comb begin
    bus.gnt_o = '0;
    if (xfer) bus.gnt_o[winner] = 1'b1;
  end

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    owner_n    = owner;
    beat_cnt_n = beat_cnt;
    lb_n       = 1'b0;
    if (xfer) begin
      case (state)
        IDLE: begin
          if (win_last || MAX_BURST == 1) begin
            ptr_n = next_port(winner);
            lb_n  = !win_last;
          end else begin
            state_n    = LOCKED;
            owner_n    = winner;
            beat_cnt_n = BCNT_W'(1);
          end
        end
        LOCKED: begin
          if (win_last || beat_cnt == BCNT_W'(MAX_BURST - 1)) begin
            state_n    = IDLE;
            ptr_n      = next_port(owner);
            beat_cnt_n = '0;
            lb_n       = !win_last;
          end else begin
            beat_cnt_n = beat_cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      owner    <= owner_n;
      beat_cnt <= beat_cnt_n;
    end
  end

  // Payload fields only load on a transfer so they hold while valid_o is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      port_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      lb_q    <= 1'b0;
    end else begin
      valid_q <= xfer;
      lb_q    <= lb_n;
      if (xfer) begin
        port_q <= winner;
        data_q <= bus.data_i[winner];
        last_q <= win_last;
      end
    end
  end

  assign bus.valid_o      = valid_q;
  assign bus.port_o       = port_q;
  assign bus.data_o       = data_q;
  assign bus.last_o       = last_q;
  assign bus.lock_break_o = lb_q;

`ifdef ARB_STATS_EN
  logic [NUM_PORTS-1:0][15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (stats_clr_i) begin
      cnt_q <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (bus.gnt_o[p] && cnt_q[p] != 16'hFFFF) cnt_q[p] <= cnt_q[p] + 16'd1;
      end
    end
  end

  assign grant_cnt_o = cnt_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr_i;
  assign grant_cnt_o      = '0;
`endif
endmodule
